// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared types, defaults and sizing helper for the round-robin burst arbiter
package rr_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      REL  = 2'd2
   } state_e;

   localparam int N_REQ_DEF = 4;
   localparam int LEN_W_DEF = 4;

   // Index width that stays at least one bit even for degenerate sizes.
   function automatic int id_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority picker (first set request at or after ptr, wrapping)
module rr_pick
   import rr_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int ID_W  = id_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [ID_W-1:0]  win_id,
   output logic             win_valid
);

   logic [N_REQ-1:0]   mask;
   logic [2*N_REQ-1:0] dbl;

   always_comb begin
      mask = '0;
      for (int i = 0; i < N_REQ; i++) begin
         mask[i] = (i >= int'(ptr));
      end
      // Low half holds requests at/after ptr, high half the full set to cover the wrap.
      dbl       = {req, req & mask};
      win_valid = |req;
      win_id    = '0;
      for (int i = 2*N_REQ-1; i >= 0; i--) begin
         if (dbl[i]) begin
            win_id = ID_W'(i % N_REQ);
         end
      end
   end

endmodule

// File: rtl/rr_burst_grant_ctrl.sv
// rtl/rr_burst_grant_ctrl.sv - round-robin burst grant controller; RR_BURST_WATCHDOG_EN adds an ownership watchdog
module rr_burst_grant_ctrl
   import rr_arb_pkg::*;
#(
   parameter int N_REQ    = N_REQ_DEF,
   parameter int LEN_W    = LEN_W_DEF,
   parameter int HOLD_MAX = 64
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*LEN_W-1:0]    req_len,
   input  logic                      beat_ack,
   output logic [N_REQ-1:0]          grant,
   output logic [id_w(N_REQ)-1:0]    grant_id,
   output logic                      busy,
   output logic                      burst_done,
   output logic                      abort
);

   localparam int ID_W = id_w(N_REQ);

   state_e            state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [N_REQ-1:0]  grant_q, grant_d;
   logic [ID_W-1:0]   grant_id_q, grant_id_d;
   logic              burst_done_q, burst_done_d;
   logic              abort_q, abort_d;

   logic [ID_W-1:0]   win_id;
   logic              win_valid;
   logic [ID_W-1:0]   next_ptr;
   logic              last_beat;
   logic              wd_expire;

   rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_pick (
      .req       (req),
      .ptr       (ptr_q),
      .win_id    (win_id),
      .win_valid (win_valid)
   );

`ifdef RR_BURST_WATCHDOG_EN
   localparam int HOLD_W = ($clog2(HOLD_MAX) > 8) ? $clog2(HOLD_MAX) : 8;
   logic [HOLD_W-1:0] hold_q, hold_d;

   assign wd_expire = (hold_q == HOLD_W'(HOLD_MAX - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_q <= '0;
      end else begin
         hold_q <= hold_d;
      end
   end

   always_comb begin
      hold_d = hold_q;
      if (state_q != OWN) begin
         hold_d = '0;
      end else if (state_d == OWN) begin
         hold_d = hold_q + 1'b1;
      end
   end
`else
   assign wd_expire = 1'b0;
`endif

   assign next_ptr  = (grant_id_q == ID_W'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;
   assign last_beat = beat_ack && (cnt_q == len_q);

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      len_d        = len_q;
      cnt_d        = cnt_q;
      grant_d      = grant_q;
      grant_id_d   = grant_id_q;
      burst_done_d = 1'b0;
      abort_d      = 1'b0;
      case (state_q)
         // The turnaround cycle also arbitrates, so back-to-back grants are one cycle apart.
         IDLE, REL: begin
            state_d = IDLE;
            if (win_valid) begin
               state_d         = OWN;
               grant_d         = '0;
               grant_d[win_id] = 1'b1;
               grant_id_d      = win_id;
               len_d           = req_len[win_id*LEN_W +: LEN_W];
               cnt_d           = '0;
            end
         end
         OWN: begin
            if (last_beat) begin
               state_d      = REL;
               grant_d      = '0;
               burst_done_d = 1'b1;
               ptr_d        = next_ptr;
            end else if (!req[grant_id_q] || wd_expire) begin
               state_d = REL;
               grant_d = '0;
               abort_d = 1'b1;
               ptr_d   = next_ptr;
            end else if (beat_ack) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         len_q        <= '0;
         cnt_q        <= '0;
         grant_q      <= '0;
         grant_id_q   <= '0;
         burst_done_q <= 1'b0;
         abort_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         len_q        <= len_d;
         cnt_q        <= cnt_d;
         grant_q      <= grant_d;
         grant_id_q   <= grant_id_d;
         burst_done_q <= burst_done_d;
         abort_q      <= abort_d;
      end
   end

   assign grant      = grant_q;
   assign grant_id   = grant_id_q;
   assign busy       = |grant_q;
   assign burst_done = burst_done_q;
   assign abort      = abort_q;

endmodule

// File: tb/tb_rr_burst_grant_ctrl.sv
// tb/tb_rr_burst_grant_ctrl.sv - self-checking bench with a behavioural arbiter model and directed scenarios
module tb_rr_burst_grant_ctrl;

   localparam int N    = 4;
   localparam int LW   = 4;
   localparam int HOLD = 16;
`ifdef RR_BURST_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req;
   logic [N*LW-1:0] req_len;
   logic            beat_ack;
   logic [N-1:0]    grant;
   logic [1:0]      grant_id;
   logic            busy;
   logic            burst_done;
   logic            abort;

   int checks = 0;
   int errors = 0;
   bit run    = 1'b0;

   rr_burst_grant_ctrl #(
      .N_REQ    (N),
      .LEN_W    (LW),
      .HOLD_MAX (HOLD)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .req_len    (req_len),
      .beat_ack   (beat_ack),
      .grant      (grant),
      .grant_id   (grant_id),
      .busy       (busy),
      .burst_done (burst_done),
      .abort      (abort)
   );

   always #5 clk = ~clk;

   // Model: who owns the resource, beats accepted, cycles held, and the rotation start point.
   typedef struct packed {
      int owner;
      int ptr;
      int beats;
      int len;
      int held;
      bit done;
      bit abort;
   } mstate_t;

   mstate_t m;

   function automatic mstate_t model_step(mstate_t s, logic [N-1:0] r, logic [N*LW-1:0] lens, logic ack);
      mstate_t n;
      bit found;
      n       = s;
      n.done  = 1'b0;
      n.abort = 1'b0;
      if (s.owner >= 0) begin
         if (ack && s.beats == s.len) begin
            n.done  = 1'b1;
            n.owner = -1;
            n.ptr   = (s.owner + 1) % N;
         end else if (!r[s.owner] || (WD && s.held == HOLD - 1)) begin
            n.abort = 1'b1;
            n.owner = -1;
            n.ptr   = (s.owner + 1) % N;
         end else begin
            n.beats = s.beats + int'(ack);
            n.held  = s.held + 1;
         end
      end else if (r != '0) begin
         found = 1'b0;
         for (int k = 0; k < N; k++) begin
            if (!found && r[(s.ptr + k) % N]) begin
               found   = 1'b1;
               n.owner = (s.ptr + k) % N;
            end
         end
         n.len   = int'((lens >> (LW * n.owner)) & 16'hF);
         n.beats = 0;
         n.held  = 0;
      end
      return n;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m <= '{owner: -1, ptr: 0, beats: 0, len: 0, held: 0, done: 1'b0, abort: 1'b0};
      end else begin
         m <= model_step(m, req, req_len, beat_ack);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (run && !reset) begin
         chk("cmp_grant", int'(grant), (m.owner >= 0) ? (1 << m.owner) : 0);
         chk("cmp_busy", int'(busy), int'(m.owner >= 0));
         chk("cmp_done", int'(burst_done), int'(m.done));
         chk("cmp_abort", int'(abort), int'(m.abort));
         if (m.owner >= 0) begin
            chk("cmp_grant_id", int'(grant_id), m.owner);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   int rot_exp [9] = '{1, 0, 2, 0, 4, 0, 8, 0, 1};

   initial begin
      reset    = 1'b1;
      req      = '0;
      req_len  = '0;
      beat_ack = 1'b0;
      cyc();
      cyc();
      chk("rst_grant", int'(grant), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_grant_id", int'(grant_id), 0);
      chk("rst_done", int'(burst_done), 0);
      chk("rst_abort", int'(abort), 0);
      reset = 1'b0;
      run   = 1'b1;

      // Pure rotation with one dead cycle between single-beat bursts.
      req      = 4'b1111;
      beat_ack = 1'b1;
      for (int i = 0; i < 9; i++) begin
         cyc();
         chk("rot_grant", int'(grant), rot_exp[i]);
         chk("rot_done", int'(burst_done), int'(i % 2 == 1));
      end
      req      = '0;
      beat_ack = 1'b0;
      cyc();
      cyc();
      cyc();

      // Four-beat burst with gapped acks, then pointer lands on 3 and wraps to requester 0.
      req            = 4'b0100;
      req_len[11:8]  = 4'd3;
      cyc();
      chk("b4_grant", int'(grant), 4'b0100);
      for (int i = 0; i < 7; i++) begin
         beat_ack = (i % 2 == 0);
         if (i == 6) req = 4'b0101;
         cyc();
         if (i < 6) chk("b4_hold", int'(grant), 4'b0100);
      end
      chk("b4_release", int'(grant), 0);
      chk("b4_done", int'(burst_done), 1);
      chk("b4_no_abort", int'(abort), 0);
      beat_ack = 1'b0;
      cyc();
      chk("b4_wrap_grant", int'(grant), 4'b0001);
      chk("b4_done_drop", int'(burst_done), 0);
      req = '0;
      cyc();
      chk("b4_withdraw_abort", int'(abort), 1);
      cyc();

      // Withdrawal after two acks of an eight-beat burst.
      req          = 4'b0010;
      req_len      = '0;
      req_len[7:4] = 4'd7;
      cyc();
      chk("wd1_grant", int'(grant), 4'b0010);
      beat_ack = 1'b1;
      cyc();
      cyc();
      req      = 4'b0101;
      beat_ack = 1'b0;
      cyc();
      chk("wd1_grant_off", int'(grant), 0);
      chk("wd1_abort", int'(abort), 1);
      chk("wd1_no_done", int'(burst_done), 0);
      cyc();
      chk("wd1_ptr2", int'(grant), 4'b0100);
      req = '0;
      cyc();
      cyc();

      // Final ack coincides with withdrawal: completion wins.
      req     = 4'b1000;
      req_len = '0;
      cyc();
      chk("tie_grant", int'(grant), 4'b1000);
      req      = '0;
      beat_ack = 1'b1;
      cyc();
      chk("tie_done", int'(burst_done), 1);
      chk("tie_abort", int'(abort), 0);
      beat_ack = 1'b0;
      cyc();

      // Asynchronous reset in the middle of a burst.
      req            = 4'b0100;
      req_len[11:8]  = 4'd5;
      cyc();
      chk("rstm_grant", int'(grant), 4'b0100);
      beat_ack = 1'b1;
      cyc();
      cyc();
      beat_ack = 1'b0;
      reset    = 1'b1;
      #1;
      chk("rstm_grant_now", int'(grant), 0);
      chk("rstm_busy_now", int'(busy), 0);
      cyc();
      req   = 4'b1000;
      reset = 1'b0;
      cyc();
      chk("rstm_regrant", int'(grant), 4'b1000);
      req = '0;
      cyc();
      cyc();

      // Long ownership without acks.
      req          = 4'b0001;
      req_len      = '0;
      req_len[3:0] = 4'd15;
      cyc();
      chk("hold_grant", int'(grant), 4'b0001);
      if (WD) begin
         repeat (15) cyc();
         chk("wdog_still_held", int'(grant), 4'b0001);
         cyc();
         chk("wdog_release", int'(grant), 0);
         chk("wdog_abort", int'(abort), 1);
      end else begin
         repeat (99) cyc();
         chk("nowdog_held_100", int'(grant), 4'b0001);
         chk("nowdog_busy_100", int'(busy), 1);
      end
      req = '0;
      cyc();
      cyc();

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) req = N'($urandom);
         if ($urandom_range(0, 7) == 0) req_len = 16'($urandom);
         else req_len = 16'($urandom) & 16'h3333;
         beat_ack = 1'($urandom_range(0, 1));
         cyc();
      end

      run = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
